// File: rtl/global_pkg.sv
// Shared types and constants for the Wishbone responders (timer register map, FSM states).
package global_pkg;

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4
  } timer_reg_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_RESP = 1'b1
  } wb_slave_state_t;

  localparam int          TIMER_CTRL_EN_BIT = 0;
  localparam logic [63:0] TIMER_CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replaces only the byte lanes selected by sel, keeping the rest of old_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Prescaler plus free-running 64-bit mtime with a byte-masked software load port.
module timer_counter
  import global_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_clear_pre,
  input  logic                  i_load_lo,
  input  logic                  i_load_hi,
  input  logic [3:0]            i_load_sel,
  input  logic [31:0]           i_load_data,
  output logic [63:0]           o_mtime
);

  logic [PRESCALE_W-1:0] r_pre;
  logic [63:0]           r_mtime;
  logic                  w_tick;

  assign w_tick  = i_enable && (r_pre == i_prescale);
  assign o_mtime = r_mtime;

  // A software load suppresses that cycle's increment for the whole 64-bit value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre   <= '0;
      r_mtime <= '0;
    end else begin
      if (i_clear_pre)
        r_pre <= '0;
      else if (i_enable)
        r_pre <= w_tick ? '0 : r_pre + 1'b1;

      if (i_load_lo || i_load_hi) begin
        if (i_load_lo) r_mtime[31:0]  <= byte_merge(r_mtime[31:0],  i_load_data, i_load_sel);
        if (i_load_hi) r_mtime[63:32] <= byte_merge(r_mtime[63:32], i_load_data, i_load_sel);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone B4 classic machine-timer responder: mtime, mtimecmp, CTRL and level interrupt.
// Optional WB_TIMER_SNAPSHOT_EN: MTIME_HI reads a shadow captured on each MTIME_LO read.
module wb_timer
  import global_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        timer_irq
);

  wb_slave_state_t       r_state;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_dat;
  logic                  r_irq;
  logic [63:0]           r_cmp;
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_prescale;

  timer_reg_t  w_idx;
  logic        w_req;
  logic        w_wr;
  logic        w_mapped;
  logic [63:0] w_mtime;
  logic [31:0] w_ctrl_word;
  logic [31:0] w_ctrl_wr;
  logic [31:0] w_hi_rd;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_idx     = timer_reg_t'(wb_adr_i[4:2]);
  assign w_mapped  = (wb_adr_i[4:2] <= 3'd4);
  assign w_req     = (r_state == WB_IDLE) && wb_cyc_i && wb_stb_i;
  assign w_wr      = w_req && wb_we_i;
  assign w_ctrl_wr = byte_merge(w_ctrl_word, wb_dat_i, wb_sel_i);
  assign w_unused  = ^{wb_adr_i[1:0], w_ctrl_wr};

  // Reset low during the response cycle aborts the transaction before it terminates.
  assign wb_ack_o  = r_ack && rst;
  assign wb_err_o  = r_err && rst;
  assign wb_dat_o  = r_dat;
  assign timer_irq = r_irq;

  timer_counter #(.PRESCALE_W(PRESCALE_W)) u_counter (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (r_en),
    .i_prescale  (r_prescale),
    .i_clear_pre (w_wr && (w_idx == REG_CTRL)),
    .i_load_lo   (w_wr && (w_idx == REG_MTIME_LO)),
    .i_load_hi   (w_wr && (w_idx == REG_MTIME_HI)),
    .i_load_sel  (wb_sel_i),
    .i_load_data (wb_dat_i),
    .o_mtime     (w_mtime)
  );

  always_comb begin
    w_ctrl_word = '0;
    w_ctrl_word[TIMER_CTRL_EN_BIT]  = r_en;
    w_ctrl_word[8 +: PRESCALE_W]    = r_prescale;
  end

`ifdef WB_TIMER_SNAPSHOT_EN
  logic [31:0] r_shadow;

  always_ff @(posedge clk) begin
    if (!rst)
      r_shadow <= '0;
    else if (w_req && !wb_we_i && (w_idx == REG_MTIME_LO))
      r_shadow <= w_mtime[63:32];
  end

  assign w_hi_rd = r_shadow;
`else
  assign w_hi_rd = w_mtime[63:32];
`endif

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_MTIME_LO: w_rdata = w_mtime[31:0];
      REG_MTIME_HI: w_rdata = w_hi_rd;
      REG_CMP_LO:   w_rdata = r_cmp[31:0];
      REG_CMP_HI:   w_rdata = r_cmp[63:32];
      REG_CTRL:     w_rdata = w_ctrl_word;
      default:      w_rdata = '0;
    endcase
  end

  // Handshake FSM: the request is fully resolved at the IDLE->RESP edge,
  // so RESP only has to drop the registered termination.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= WB_IDLE;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_cmp      <= TIMER_CMP_RESET;
      r_en       <= CTRL_RESET[TIMER_CTRL_EN_BIT];
      r_prescale <= CTRL_RESET[8 +: PRESCALE_W];
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (w_req) begin
            r_state <= WB_RESP;
            r_ack   <= w_mapped;
            r_err   <= !w_mapped;
            r_dat   <= (w_mapped && !wb_we_i) ? w_rdata : 32'd0;
            if (wb_we_i) begin
              if (w_idx == REG_CMP_LO) r_cmp[31:0]  <= byte_merge(r_cmp[31:0],  wb_dat_i, wb_sel_i);
              if (w_idx == REG_CMP_HI) r_cmp[63:32] <= byte_merge(r_cmp[63:32], wb_dat_i, wb_sel_i);
              if (w_idx == REG_CTRL) begin
                r_en       <= w_ctrl_wr[TIMER_CTRL_EN_BIT];
                r_prescale <= w_ctrl_wr[8 +: PRESCALE_W];
              end
            end
          end
        end
        WB_RESP: begin
          r_state <= WB_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_dat   <= '0;
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_irq <= 1'b0;
    else
      r_irq <= r_en && (w_mtime >= r_cmp);
  end

endmodule
